// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its control unit.
package mult_div_pkg;

    // Operand width and number of iterations per operation.
    localparam int unsigned ITER = 32;

    // Exception cause code raised by the control unit on a divide-by-zero.
    localparam logic [4:0] CAUSE_DIV_ZERO = 5'h0F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_div_if.sv
// Operand/result bundle between the control unit (master) and the mult/div engine (slave).
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             busy;
    logic             div_zero;

    modport master (
        output mult_start, div_start, a, b,
        input  hi, lo, ready, busy, div_zero
    );

    modport slave (
        input  mult_start, div_start, a, b,
        output hi, lo, ready, busy, div_zero
    );
endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Keep the difference when it is non-negative, otherwise restore the shifted remainder.
    always_comb begin
        trial   = {rem_in, bit_in};
        diff    = trial - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) engine feeding HI/LO.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = ITER,
    parameter int unsigned CNT_W = 6
) (
    input logic       clk,
    input logic       reset,
    mult_div_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   acc;        // {P, multiplier/low product, q(-1)}
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               quo_neg;
    logic               rem_neg;
    logic               dz_q;
    logic               ready;
    logic               busy;
    logic               div_zero;
    logic               iter_done;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    assign iter_done    = (cnt == LAST);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.ready    = ready;
    assign bus.busy     = busy;
    assign bus.div_zero = div_zero;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .divisor (dvs),
        .bit_in  (quo[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b1;
        div_zero  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.mult_start)     state_nxt = S_MULT;
                else if (bus.div_start) state_nxt = (bus.b == '0) ? S_DONE : S_DIV;
            end
            S_MULT, S_DIV: begin
                if (iter_done) state_nxt = S_DONE;
            end
            default: begin
                ready     = 1'b1;
                div_zero  = dz_q;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Booth add/subtract on P; the sum is one bit wider so that subtracting the
    // most-negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        case (acc[1:0])
            2'b01:   booth_sum = booth_sum + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_sum - {mcand[WIDTH-1], mcand};
            default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        endcase
    end

    // Operand capture, iteration, counter and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    dz_q <= bus.div_start && !bus.mult_start && (bus.b == '0);
                    if (bus.mult_start) begin
                        acc   <= {{WIDTH{1'b0}}, bus.b, 1'b0};
                        mcand <= bus.a;
                    end else if (bus.div_start) begin
                        quo     <= bus.a[WIDTH-1] ? -bus.a : bus.a;
                        dvs     <= bus.b[WIDTH-1] ? -bus.b : bus.b;
                        rem     <= '0;
                        quo_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rem_neg <= bus.a[WIDTH-1];
                    end
                end
                S_MULT: begin
                    if (iter_done) begin
                        hi_q <= acc[2*WIDTH:WIDTH+1];
                        lo_q <= acc[WIDTH:1];
                        cnt  <= '0;
                    end else begin
                        acc <= {booth_sum, acc[WIDTH:1]};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (iter_done) begin
                        lo_q <= quo_neg ? -quo : quo;
                        hi_q <= rem_neg ? -rem : rem;
                        cnt  <= '0;
                    end else begin
                        rem <= step_rem;
                        quo <= {quo[WIDTH-2:0], step_q};
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule
